// File: rtl/ps2_scan_ctrl_pkg.sv
// Shared definitions for the PS/2 scan-code controller: FSM encoding,
// protocol prefix bytes and the decoded-event classification.
package ps2_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK   = 2'd1,
    ST_GAP   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_MAKE   = 2'd1,
    EV_REPEAT = 2'd2,
    EV_BREAK  = 2'd3
  } key_ev_t;

  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;

  // Receiver clear is held low for this many cycles on overflow.
  localparam int FLUSH_CYC = 2;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_BRK) || (b == PS2_EXT);
  endfunction

endpackage

// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-code controller: pops bytes from the keyboard receiver FIFO,
// strips E0/F0 prefixes and reports make / typematic repeat / break events.
module ps2_scan_ctrl
  import ps2_scan_ctrl_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int GAP_CYC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic             overflow,
  input  logic [7:0]       data,
  output logic             nextdata_n,
  output logic             clrn,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_make,
  output logic             key_repeat,
  output logic             key_break,
  output logic             key_held,
  output logic [CNT_W-1:0] press_count,
  output logic             ovf_seen
);

  localparam logic [1:0] GAP_LAST   = 2'(GAP_CYC - 1);
  localparam logic       FLUSH_LAST = 1'(FLUSH_CYC - 1);

  state_t     state_reg, state_next;
  logic [1:0] gap_cnt_reg, gap_cnt_next;
  logic       flush_cnt_reg, flush_cnt_next;
  logic       nextdata_n_reg, nextdata_n_next;
  logic       clrn_reg, clrn_next;
  logic       take_byte;
  logic       enter_flush;

  logic [7:0]       key_code_reg;
  logic             key_ext_reg;
  logic             key_make_reg, key_repeat_reg, key_break_reg;
  logic             key_held_reg;
  logic [7:0]       held_code_reg;
  logic             held_ext_reg;
  logic [CNT_W-1:0] press_count_reg;
  logic             ovf_seen_reg;
  logic             brk_pend_reg, ext_pend_reg;
  logic             held_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      gap_cnt_reg    <= 2'd0;
      flush_cnt_reg  <= 1'b0;
      nextdata_n_reg <= 1'b1;
      clrn_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      gap_cnt_reg    <= gap_cnt_next;
      flush_cnt_reg  <= flush_cnt_next;
      nextdata_n_reg <= nextdata_n_next;
      clrn_reg       <= clrn_next;
    end
  end

  // clrn is still low on the first cycle out of reset, so that cycle only
  // releases the receiver and ready is not looked at until the next one.
  always_comb begin
    state_next      = state_reg;
    gap_cnt_next    = gap_cnt_reg;
    flush_cnt_next  = flush_cnt_reg;
    nextdata_n_next = 1'b1;
    clrn_next       = 1'b1;
    take_byte       = 1'b0;
    enter_flush     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (clrn_reg) begin
          if (overflow) begin
            state_next     = ST_FLUSH;
            flush_cnt_next = 1'b0;
            clrn_next      = 1'b0;
            enter_flush    = 1'b1;
          end else if (ready) begin
            state_next      = ST_ACK;
            nextdata_n_next = 1'b0;
            take_byte       = 1'b1;
          end
        end
      end
      ST_ACK: begin
        state_next   = ST_GAP;
        gap_cnt_next = 2'd0;
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = ST_IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 2'd1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_reg == FLUSH_LAST) begin
          state_next = ST_IDLE;
        end else begin
          clrn_next      = 1'b0;
          flush_cnt_next = flush_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign held_match = key_held_reg && (held_code_reg == data) &&
                      (held_ext_reg == ext_pend_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      key_code_reg    <= 8'h00;
      key_ext_reg     <= 1'b0;
      key_make_reg    <= 1'b0;
      key_repeat_reg  <= 1'b0;
      key_break_reg   <= 1'b0;
      key_held_reg    <= 1'b0;
      held_code_reg   <= 8'h00;
      held_ext_reg    <= 1'b0;
      press_count_reg <= '0;
      ovf_seen_reg    <= 1'b0;
      brk_pend_reg    <= 1'b0;
      ext_pend_reg    <= 1'b0;
    end else begin
      key_make_reg   <= 1'b0;
      key_repeat_reg <= 1'b0;
      key_break_reg  <= 1'b0;
      if (enter_flush) begin
        brk_pend_reg <= 1'b0;
        ext_pend_reg <= 1'b0;
        key_held_reg <= 1'b0;
        ovf_seen_reg <= 1'b1;
      end else if (take_byte) begin
        if (data == PS2_BRK) begin
          brk_pend_reg <= 1'b1;
        end else if (data == PS2_EXT) begin
          ext_pend_reg <= 1'b1;
        end else begin
          key_code_reg <= data;
          key_ext_reg  <= ext_pend_reg;
          brk_pend_reg <= 1'b0;
          ext_pend_reg <= 1'b0;
          if (brk_pend_reg) begin
            key_break_reg <= 1'b1;
            if (held_match) key_held_reg <= 1'b0;
          end else if (held_match) begin
            key_repeat_reg <= 1'b1;
          end else begin
            // A new press replaces whatever key was previously held.
            key_make_reg    <= 1'b1;
            press_count_reg <= press_count_reg + CNT_W'(1);
            key_held_reg    <= 1'b1;
            held_code_reg   <= data;
            held_ext_reg    <= ext_pend_reg;
          end
        end
      end
    end
  end

  assign nextdata_n  = nextdata_n_reg;
  assign clrn        = clrn_reg;
  assign key_code    = key_code_reg;
  assign key_ext     = key_ext_reg;
  assign key_make    = key_make_reg;
  assign key_repeat  = key_repeat_reg;
  assign key_break   = key_break_reg;
  assign key_held    = key_held_reg;
  assign press_count = press_count_reg;
  assign ovf_seen    = ovf_seen_reg;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Self-checking bench for ps2_scan_ctrl: a queue-based receiver FIFO feeds
// bytes, and each pop is compared with a scan-code reference model.
module tb_ps2_scan_ctrl;
  import ps2_scan_ctrl_pkg::*;

  localparam int CNT_W   = 8;
  localparam int GAP_CYC = 1;

  logic clk = 1'b0;
  logic reset, ready, overflow;
  logic [7:0] data;
  logic nextdata_n, clrn, key_ext, key_make, key_repeat, key_break, key_held, ovf_seen;
  logic [7:0] key_code;
  logic [CNT_W-1:0] press_count;

  ps2_scan_ctrl #(.CNT_W(CNT_W), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .reset(reset), .ready(ready), .overflow(overflow), .data(data),
    .nextdata_n(nextdata_n), .clrn(clrn), .key_code(key_code), .key_ext(key_ext),
    .key_make(key_make), .key_repeat(key_repeat), .key_break(key_break),
    .key_held(key_held), .press_count(press_count), .ovf_seen(ovf_seen)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       ev;
    logic [7:0]       code;
    logic             ext;
    logic             held;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] fifo_q[$];
  obs_t obs_q[$];
  obs_t exp_q[$];
  int   pop_cyc_q[$];
  int   stray, low_cnt;
  bit   timed_out;

  // Reference model: keyboard state as seen from the scan-code rules.
  bit m_brk, m_ext, m_held, m_hext, m_kext;
  logic [7:0] m_hcode, m_code;
  int m_cnt;

  task automatic model_clear();
    m_brk = 0; m_ext = 0; m_held = 0; m_hext = 0; m_kext = 0;
    m_hcode = 8'h00; m_code = 8'h00; m_cnt = 0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    obs_t e;
    bit same;
    logic [1:0] ev;
    ev = 2'd0;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else begin
      same = m_held && (m_hcode == b) && (m_hext == m_ext);
      m_code = b;
      m_kext = m_ext;
      if (m_brk) begin
        ev = 2'd3;
        if (same) m_held = 0;
      end else if (same) begin
        ev = 2'd2;
      end else begin
        ev = 2'd1;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        m_held = 1; m_hcode = b; m_hext = m_ext;
      end
      m_brk = 0; m_ext = 0;
    end
    e.ev = ev; e.code = m_code; e.ext = m_kext; e.held = m_held; e.cnt = CNT_W'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1; ready = 0; overflow = 0; data = 8'h00;
    fifo_q.delete();
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    model_clear();
  endtask

  // Feeds bytes into the FIFO model (optionally with random idle gaps) and
  // records the DUT outputs seen in every pop-strobe cycle.
  task automatic pump(input logic [7:0] bytes[$], input bit gaps);
    int idx, idle, budget, pulses;
    obs_t o;
    idx = 0; idle = 0;
    budget = 30 * bytes.size() + 40;
    obs_q.delete(); pop_cyc_q.delete();
    stray = 0; low_cnt = 0; timed_out = 0;
    forever begin
      @(negedge clk);
      pulses = int'(key_make) + int'(key_repeat) + int'(key_break);
      if (pulses > 1) stray++;
      if (!nextdata_n) begin
        low_cnt++;
        o.ev   = key_break ? 2'd3 : key_repeat ? 2'd2 : key_make ? 2'd1 : 2'd0;
        o.code = key_code; o.ext = key_ext; o.held = key_held; o.cnt = press_count;
        obs_q.push_back(o);
        pop_cyc_q.push_back(cyc);
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end else if (pulses != 0) begin
        stray++;
      end
      if (idx < bytes.size() && (!gaps || $urandom_range(0, 2) == 0)) begin
        fifo_q.push_back(bytes[idx]);
        idx++;
      end
      ready = (fifo_q.size() > 0);
      data  = ready ? fifo_q[0] : 8'h00;
      if (idx == bytes.size() && fifo_q.size() == 0 && nextdata_n) idle++;
      else idle = 0;
      if (idle >= 6) break;
      budget--;
      if (budget == 0) begin
        timed_out = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1; overflow = 0; ready = 1; data = 8'h1C;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({nextdata_n, clrn} !== 2'b10) begin
      n_bad++; $display("FAIL reset_strobes got nextdata_n,clrn=%b want=10", {nextdata_n, clrn});
    end
    n_cmp++;
    if ({key_code, key_ext, key_make, key_repeat, key_break, key_held, ovf_seen} !== 14'h0) begin
      n_bad++; $display("FAIL reset_regs got code=%h ext=%b pulses=%b held=%b ovf=%b want all 0",
                        key_code, key_ext, {key_make, key_repeat, key_break}, key_held, ovf_seen);
    end
    n_cmp++;
    if (press_count !== '0) begin
      n_bad++; $display("FAIL reset_count got=%0d want=0", press_count);
    end
    reset = 0;
    @(negedge clk);
    n_cmp++;
    if ({clrn, nextdata_n} !== 2'b11) begin
      n_bad++; $display("FAIL reset_release got clrn,nextdata_n=%b want=11", {clrn, nextdata_n});
    end
    @(negedge clk);
    n_cmp++;
    if ({nextdata_n, key_make, key_code, press_count} !== {1'b0, 1'b1, 8'h1C, CNT_W'(1)}) begin
      n_bad++; $display("FAIL reset_first_sample got nextdata_n=%b make=%b code=%h cnt=%0d want 0 1 1c 1",
                        nextdata_n, key_make, key_code, press_count);
    end
    ready = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] b[$];
    do_reset();
    b = '{8'h1C, 8'hF0, 8'h1C};
    foreach (b[i]) model_byte(b[i]);
    pump(b, 0);
    n_cmp++;
    if ({timed_out, obs_q.size(), stray, low_cnt} !== {1'b0, 32'd3, 32'd0, 32'd3}) begin
      n_bad++; $display("FAIL basic_shape got timeout=%0b pops=%0d stray=%0d low=%0d want 0 3 0 3",
                        timed_out, obs_q.size(), stray, low_cnt);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL basic_byte%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i < pop_cyc_q.size(); i++) begin
      n_cmp++;
      if (pop_cyc_q[i] - pop_cyc_q[i-1] !== 2 + GAP_CYC) begin
        n_bad++; $display("FAIL back_to_back_gap%0d got=%0d want=%0d", i,
                          pop_cyc_q[i] - pop_cyc_q[i-1], 2 + GAP_CYC);
      end
    end
  endtask

  task automatic test_repeat_and_ext();
    logic [7:0] b[$];
    do_reset();
    b = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75,
          8'hF0, 8'hF0, 8'h32, 8'hF0, 8'hE0, 8'h75};
    foreach (b[i]) model_byte(b[i]);
    pump(b, 1);
    n_cmp++;
    if ({timed_out, obs_q.size(), stray} !== {1'b0, exp_q.size(), 32'd0}) begin
      n_bad++; $display("FAIL rep_ext_shape got timeout=%0b pops=%0d stray=%0d want 0 %0d 0",
                        timed_out, obs_q.size(), stray, exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL rep_ext_byte%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b[$];
    do_reset();
    b = '{8'h1C};
    model_byte(8'h1C);
    pump(b, 0);
    overflow = 1; ready = 1; data = 8'h75; fifo_q.push_back(8'h75);
    @(negedge clk);
    n_cmp++;
    if ({clrn, nextdata_n, key_make, key_repeat, key_break, ovf_seen, key_held} !== 7'b0100010) begin
      n_bad++; $display("FAIL ovf_enter got clrn=%b ndn=%b pulses=%b ovf=%b held=%b want 0 1 000 1 0",
                        clrn, nextdata_n, {key_make, key_repeat, key_break}, ovf_seen, key_held);
    end
    overflow = 0;
    @(negedge clk);
    n_cmp++;
    if ({clrn, nextdata_n, key_make, key_repeat, key_break} !== 5'b01000) begin
      n_bad++; $display("FAIL ovf_second got clrn=%b ndn=%b pulses=%b want 0 1 000",
                        clrn, nextdata_n, {key_make, key_repeat, key_break});
    end
    fifo_q.delete(); ready = 0; data = 8'h00;
    @(negedge clk);
    n_cmp++;
    if ({clrn, key_code, press_count} !== {1'b1, 8'h1C, CNT_W'(1)}) begin
      n_bad++; $display("FAIL ovf_exit got clrn=%b code=%h cnt=%0d want 1 1c 1", clrn, key_code, press_count);
    end
    m_brk = 0; m_ext = 0; m_held = 0;
    exp_q.delete();
    model_byte(8'h1C);
    pump(b, 0);
    n_cmp++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      n_bad++; $display("FAIL ovf_after got pops=%0d first=%h want 1 %h", obs_q.size(),
                        (obs_q.size() > 0) ? obs_q[0] : obs_t'(0), exp_q[0]);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] b[$];
    logic [7:0] code;
    int bad;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      code = 8'(i);
      if (code == 8'hF0 || code == 8'hE0) begin
        code = (code == 8'hF0) ? 8'h01 : 8'h02;
        b.push_back(8'hE0); b.push_back(code); b.push_back(8'hE0);
      end else begin
        b.push_back(code);
      end
      b.push_back(8'hF0); b.push_back(code);
    end
    foreach (b[i]) model_byte(b[i]);
    pump(b, 0);
    bad = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad++;
    n_cmp++;
    if ({timed_out, obs_q.size(), bad} !== {1'b0, exp_q.size(), 32'd0}) begin
      n_bad++; $display("FAIL wrap_stream got timeout=%0b pops=%0d bad=%0d want 0 %0d 0",
                        timed_out, obs_q.size(), bad, exp_q.size());
    end
    n_cmp++;
    if (press_count !== CNT_W'(m_cnt) || m_cnt != 0) begin
      n_bad++; $display("FAIL wrap_count got=%0d want=0", press_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool[6] = '{8'h1C, 8'h1C, 8'h75, 8'hF0, 8'hE0, 8'h32};
    logic [7:0] b[$];
    do_reset();
    for (int i = 0; i < 60; i++) b.push_back(pool[$urandom_range(0, 5)]);
    foreach (b[i]) model_byte(b[i]);
    pump(b, 1);
    n_cmp++;
    if ({timed_out, obs_q.size(), stray} !== {1'b0, exp_q.size(), 32'd0}) begin
      n_bad++; $display("FAIL rand_shape got timeout=%0b pops=%0d stray=%0d want 0 %0d 0",
                        timed_out, obs_q.size(), stray, exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL rand_byte%0d got=%h want=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_in_ack();
    int waited;
    do_reset();
    ready = 1; data = 8'h1C;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (nextdata_n && waited < 10);
    n_cmp++;
    if (nextdata_n !== 1'b0) begin
      n_bad++; $display("FAIL rst_ack_wait got nextdata_n=%b want 0 within 10 cycles", nextdata_n);
    end
    reset = 1; ready = 0; data = 8'h00;
    @(negedge clk);
    n_cmp++;
    if ({nextdata_n, clrn, press_count, key_held, key_code} !== {1'b1, 1'b0, CNT_W'(0), 1'b0, 8'h00}) begin
      n_bad++; $display("FAIL rst_ack got ndn=%b clrn=%b cnt=%0d held=%b code=%h want 1 0 0 0 00",
                        nextdata_n, clrn, press_count, key_held, key_code);
    end
    reset = 0;
    repeat (2) @(negedge clk);
    model_clear();
  endtask

  initial begin
    reset = 1; ready = 0; overflow = 0; data = 8'h00;
    test_reset();
    test_basic();
    test_repeat_and_ext();
    test_overflow();
    test_wrap();
    test_random();
    test_reset_in_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
